// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the instruction-fetch slice.
//   - Default instruction width and sequential PC step.
//   - NOP encoding (addi x0, x0, 0).
//   - Fetch FSM state enum.
//   - Pointer/count width helpers for power-of-two FIFOs.
package cpu_pkg;

    localparam int unsigned INSTR_W_DEFAULT = 32;
    localparam int unsigned PC_STEP_DEFAULT = 4;
    localparam logic [31:0] NOP_INSTR       = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    // Read/write pointer width; pointers wrap naturally at the power-of-two depth.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Occupancy counter needs one extra bit to tell full from empty.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with flush, used as the fetch prefetch buffer.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   push, wdata   write request and data
//   pop           read request (head advances at the edge)
//   flush         discard all entries; wins over push and pop
//   rdata         entry at the head (meaningful only when !empty)
//   full, empty   occupancy flags
//   count         number of occupied entries
module sync_fifo
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = 96,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    input  logic                       flush,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PW = ptr_width(DEPTH);
    localparam int unsigned CW = cnt_width(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    // A push at full is legal only when the head leaves in the same cycle.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: entries are only read once counted as valid.
    always_ff @(posedge clk) begin
        if (do_push && !flush && !rst) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage. Owns the fetch PC, issues reads to a
// synchronous instruction SRAM (1-cycle latency), buffers {instr, pc} in a
// prefetch FIFO and hands entries to decode over valid/ready. Redirect flushes
// the FIFO, kills any inflight read and retargets the fetch PC.
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   enable                fetch permitted (IDLE/RUN/DRAIN control)
//   imem_addr, imem_ren   SRAM read request
//   imem_rdata            SRAM data, valid the cycle after imem_ren
//   redirect, redirect_pc branch/jump target (bits [1:0] forced to zero)
//   out_valid/out_ready   decode handshake; out_instr/out_pc are the FIFO head
//   fifo_count            occupied prefetch entries
// Build option: define FETCH_BYPASS_EN to present a response arriving into an
// empty FIFO combinationally on the outputs (1-cycle fetch-to-valid latency).
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned       DATA_W     = 64,
    parameter int unsigned       INSTR_W    = INSTR_W_DEFAULT,
    parameter int unsigned       FIFO_DEPTH = 4,
    parameter logic [DATA_W-1:0] RESET_PC   = '0,
    parameter int unsigned       PC_STEP    = PC_STEP_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    output logic [DATA_W-1:0]             imem_addr,
    output logic                          imem_ren,
    input  logic [INSTR_W-1:0]            imem_rdata,
    input  logic                          redirect,
    input  logic [DATA_W-1:0]             redirect_pc,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [INSTR_W-1:0]            out_instr,
    output logic [DATA_W-1:0]             out_pc,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned CW = cnt_width(FIFO_DEPTH);
    localparam int unsigned EW = INSTR_W + DATA_W;

    fetch_state_e      state_q, state_d;
    logic [DATA_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [DATA_W-1:0] inflight_pc_q;
    logic              inflight_q;

    logic              issue, resp_valid, push, pop;
    logic              fifo_full, fifo_empty;
    logic [EW-1:0]     fifo_rdata;
    logic [CW-1:0]     count;

    // Credit check: buffered plus inflight entries must leave room for the new read.
    assign issue      = (state_q == RUN) && !redirect &&
                        ((count + CW'(inflight_q)) < CW'(FIFO_DEPTH));
    // A response landing in a redirect cycle belongs to the old path.
    assign resp_valid = inflight_q && !redirect;

    assign imem_ren   = issue;
    assign imem_addr  = fetch_pc_q;
    assign fifo_count = count;

`ifdef FETCH_BYPASS_EN
    logic bypass;
    assign bypass    = fifo_empty && resp_valid;
    assign push      = resp_valid && !(bypass && out_ready) && (!fifo_full || pop);
    assign pop       = !fifo_empty && out_ready && !redirect;
    assign out_valid = !fifo_empty || bypass;
    always_comb begin
        out_instr = '0;
        out_pc    = '0;
        if (!fifo_empty) begin
            out_instr = fifo_rdata[EW-1:DATA_W];
            out_pc    = fifo_rdata[DATA_W-1:0];
        end else if (bypass) begin
            out_instr = imem_rdata;
            out_pc    = inflight_pc_q;
        end
    end
`else
    assign push      = resp_valid && (!fifo_full || pop);
    assign pop       = !fifo_empty && out_ready && !redirect;
    assign out_valid = !fifo_empty;
    // Zero when empty so reset/flush leave clean outputs.
    assign out_instr = fifo_empty ? '0 : fifo_rdata[EW-1:DATA_W];
    assign out_pc    = fifo_empty ? '0 : fifo_rdata[DATA_W-1:0];
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (enable) state_d = RUN;
            RUN:     if (!enable) state_d = DRAIN;
            DRAIN: begin
                if (enable) begin
                    state_d = RUN;
                end else if (fifo_empty && !inflight_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (redirect) begin
            fetch_pc_d = redirect_pc & ~DATA_W'(3);
        end else if (issue) begin
            fetch_pc_d = fetch_pc_q + DATA_W'(PC_STEP);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= issue;
            if (issue) inflight_pc_q <= fetch_pc_q;
        end
    end

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata ({imem_rdata, inflight_pc_q}),
        .pop   (pop),
        .flush (redirect),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (count)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit with default parameters. The instruction
// memory model returns addr>>2 one cycle after each read request.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst, enable, redirect, out_ready;
    logic [63:0] redirect_pc, imem_addr, out_pc;
    logic        imem_ren, out_valid;
    logic [31:0] imem_rdata = '0;
    logic [31:0] out_instr;
    logic [2:0]  fifo_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (imem_ren) imem_rdata <= 32'(imem_addr >> 2);
    end

    fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .imem_addr   (imem_addr),
        .imem_ren    (imem_ren),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .fifo_count  (fifo_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; enable = 1'b0; out_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b1; out_ready = 1'b1; redirect = 1'b0; redirect_pc = '0;
        tick();
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++;
            $display("FAIL reset_valid: got %0d want 0", out_valid); end
        checks++; if (imem_ren !== 1'b0) begin errors++;
            $display("FAIL reset_ren: got %0d want 0", imem_ren); end
        checks++; if (out_instr !== 32'h0 || out_pc !== 64'h0) begin errors++;
            $display("FAIL reset_out: got instr=%h pc=%h want 0/0", out_instr, out_pc); end
        checks++; if (fifo_count !== 3'd0) begin errors++;
            $display("FAIL reset_count: got %0d want 0", fifo_count); end
        rst = 1'b0; enable = 1'b0; out_ready = 1'b0;
        tick();
    endtask

    task automatic test_sequential();
        do_reset();
        enable = 1'b1; out_ready = 1'b1;
        for (int n = 1; n <= 7; n++) begin
            tick();
            checks++; if (imem_ren !== 1'b1 || imem_addr !== 64'(4 * (n - 1))) begin errors++;
                $display("FAIL seq_issue[%0d]: got ren=%0d addr=%h want 1/%h",
                         n, imem_ren, imem_addr, 64'(4 * (n - 1))); end
            if (n >= 3) begin
                checks++;
                if (out_valid !== 1'b1 || out_pc !== 64'(4 * (n - 3)) ||
                    out_instr !== 32'(n - 3)) begin errors++;
                    $display("FAIL seq_out[%0d]: got v=%0d pc=%h instr=%h want 1/%h/%h",
                             n, out_valid, out_pc, out_instr, 64'(4 * (n - 3)), 32'(n - 3)); end
            end else begin
                checks++; if (out_valid !== 1'b0) begin errors++;
                    $display("FAIL seq_early_valid[%0d]: got %0d want 0", n, out_valid); end
            end
        end
    endtask

    task automatic test_backpressure();
        int issues;
        do_reset();
        enable = 1'b1; out_ready = 1'b0;
        issues = 0;
        for (int n = 1; n <= 7; n++) begin
            tick();
            if (imem_ren === 1'b1) begin
                checks++; if (imem_addr !== 64'(4 * issues)) begin errors++;
                    $display("FAIL bp_addr: got %h want %h", imem_addr, 64'(4 * issues)); end
                issues++;
            end
        end
        checks++; if (issues != 4) begin errors++;
            $display("FAIL bp_issue_count: got %0d want 4", issues); end
        checks++; if (fifo_count !== 3'd4) begin errors++;
            $display("FAIL bp_count: got %0d want 4", fifo_count); end
        checks++; if (out_valid !== 1'b1 || out_pc !== 64'h0 || out_instr !== 32'h0) begin
            errors++;
            $display("FAIL bp_hold: got v=%0d pc=%h instr=%h want 1/0/0",
                     out_valid, out_pc, out_instr); end
        out_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            checks++; if (out_valid !== 1'b1 || out_pc !== 64'(4 * k)) begin errors++;
                $display("FAIL bp_release[%0d]: got v=%0d pc=%h want 1/%h",
                         k, out_valid, out_pc, 64'(4 * k)); end
        end
    endtask

    task automatic test_redirect();
        do_reset();
        enable = 1'b1; out_ready = 1'b0;
        for (int n = 1; n <= 5; n++) tick();
        checks++; if (fifo_count !== 3'd3) begin errors++;
            $display("FAIL rd_pre_count: got %0d want 3", fifo_count); end
        redirect = 1'b1; redirect_pc = 64'h103;
        #1;
        checks++; if (imem_ren !== 1'b0) begin errors++;
            $display("FAIL rd_no_issue: got ren=%0d want 0", imem_ren); end
        tick();
        checks++; if (fifo_count !== 3'd0 || out_valid !== 1'b0) begin errors++;
            $display("FAIL rd_flush: got count=%0d v=%0d want 0/0", fifo_count, out_valid); end
        redirect = 1'b0;
        #1;
        checks++; if (imem_ren !== 1'b1 || imem_addr !== 64'h100) begin errors++;
            $display("FAIL rd_first_issue: got ren=%0d addr=%h want 1/100", imem_ren, imem_addr);
        end
        tick();
        checks++; if (imem_addr !== 64'h104 || out_valid !== 1'b0) begin errors++;
            $display("FAIL rd_second: got addr=%h v=%0d want 104/0", imem_addr, out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_pc !== 64'h100 || out_instr !== 32'h40 ||
                      fifo_count !== 3'd1) begin errors++;
            $display("FAIL rd_out: got v=%0d pc=%h instr=%h count=%0d want 1/100/40/1",
                     out_valid, out_pc, out_instr, fifo_count); end
        tick();
        checks++; if (out_pc !== 64'h100 || fifo_count !== 3'd2) begin errors++;
            $display("FAIL rd_hold: got pc=%h count=%0d want 100/2", out_pc, fifo_count); end
    endtask

    task automatic test_drain();
        do_reset();
        enable = 1'b1; out_ready = 1'b0;
        tick();
        tick();
        enable = 1'b0;
        tick();
        checks++; if (imem_ren !== 1'b0) begin errors++;
            $display("FAIL dr_stop: got ren=%0d want 0", imem_ren); end
        tick();
        checks++; if (fifo_count !== 3'd2 || out_pc !== 64'h0 || imem_ren !== 1'b0) begin
            errors++;
            $display("FAIL dr_buffered: got count=%0d pc=%h ren=%0d want 2/0/0",
                     fifo_count, out_pc, imem_ren); end
        out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b1 || out_pc !== 64'h4 || fifo_count !== 3'd1) begin
            errors++;
            $display("FAIL dr_second: got v=%0d pc=%h count=%0d want 1/4/1",
                     out_valid, out_pc, fifo_count); end
        tick();
        checks++; if (out_valid !== 1'b0 || fifo_count !== 3'd0) begin errors++;
            $display("FAIL dr_empty: got v=%0d count=%0d want 0/0", out_valid, fifo_count); end
        tick();
        tick();
        checks++; if (imem_ren !== 1'b0 || out_valid !== 1'b0) begin errors++;
            $display("FAIL dr_idle: got ren=%0d v=%0d want 0/0", imem_ren, out_valid); end
    endtask

    task automatic test_wrap();
        do_reset();
        redirect = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFE;
        tick();
        redirect = 1'b0; enable = 1'b1; out_ready = 1'b1;
        tick();
        checks++; if (imem_ren !== 1'b1 || imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin
            errors++;
            $display("FAIL wrap_top: got ren=%0d addr=%h want 1/fffffffffffffffc",
                     imem_ren, imem_addr); end
        tick();
        checks++; if (imem_ren !== 1'b1 || imem_addr !== 64'h0) begin errors++;
            $display("FAIL wrap_zero: got ren=%0d addr=%h want 1/0", imem_ren, imem_addr); end
        tick();
        checks++; if (out_pc !== 64'hFFFF_FFFF_FFFF_FFFC || out_instr !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL wrap_out: got pc=%h instr=%h want fffffffffffffffc/ffffffff",
                     out_pc, out_instr); end
    endtask

    task automatic test_bypass();
        do_reset();
        enable = 1'b1; out_ready = 1'b1;
        tick();
        checks++; if (imem_ren !== 1'b1 || out_valid !== 1'b0) begin errors++;
            $display("FAIL bypass_issue: got ren=%0d v=%0d want 1/0", imem_ren, out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_pc !== 64'h0 || fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL bypass_first: got v=%0d pc=%h count=%0d want 1/0/0",
                     out_valid, out_pc, fifo_count); end
        tick();
        checks++; if (out_pc !== 64'h4 || out_instr !== 32'h1 || fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL bypass_second: got pc=%h instr=%h count=%0d want 4/1/0",
                     out_pc, out_instr, fifo_count); end
        out_ready = 1'b0;
        tick();
        checks++; if (out_pc !== 64'h4 || fifo_count !== 3'd1) begin errors++;
            $display("FAIL bypass_pushed: got pc=%h count=%0d want 4/1", out_pc, fifo_count); end
    endtask

    initial begin
        test_reset();
`ifdef FETCH_BYPASS_EN
        test_bypass();
`else
        test_sequential();
        test_backpressure();
        test_redirect();
        test_drain();
        test_wrap();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, want finish before 200000");
        $fatal(1);
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Parametrised instruction-fetch stage, the successor to the single-cycle PC plus instruction-memory path.
- Owns the fetch PC and issues reads to the synchronous instruction SRAM (1-cycle read latency).
- Buffers returned instructions with their PCs in a prefetch FIFO and hands them to decode over a valid/ready handshake.
- Supports branch/jump redirect with flush, so a pipelined core can stall decode without losing fetches.

Parameters:
DATA_W, 64, PC/address width
INSTR_W, 32, instruction width
FIFO_DEPTH, 4, prefetch entries; power of two, >=2
RESET_PC, 0, fetch PC after reset
PC_STEP, 4, byte increment per sequential fetch

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
enable  in  1  fetch permitted; low stops new issues
imem_addr  out  DATA_W  instruction memory address
imem_ren  out  1  read request; data returns next cycle
imem_rdata  in  INSTR_W  instruction read data, valid cycle after imem_ren
redirect  in  1  branch/jump taken; flush and refetch
redirect_pc  in  DATA_W  new fetch target; bits [1:0] ignored (forced 0)
out_valid  out  1  out_instr/out_pc valid
out_ready  in  1  decode accepts entry
out_instr  out  INSTR_W  instruction at FIFO head
out_pc  out  DATA_W  PC of out_instr
fifo_count  out  $clog2(FIFO_DEPTH)+1  occupied entries

Behaviour:
- Reset (rst=1 at edge):
  - fetch_pc=RESET_PC, FIFO empty, inflight=0, state=IDLE.
  - out_valid=0, imem_ren=0, out_instr=0, out_pc=0, fifo_count=0.
  - Reset mid-operation discards everything, including any inflight read.
- FSM states and transitions:
  - IDLE -> RUN when enable=1.
  - RUN -> DRAIN when enable=0.
  - DRAIN -> RUN when enable=1.
  - DRAIN -> IDLE when FIFO empty and inflight=0.
  - Only RUN issues reads. DRAIN keeps delivering buffered entries.
- Issue:
  - Condition: state=RUN and !redirect and (fifo_count + inflight) < FIFO_DEPTH.
  - On issue: imem_ren=1, imem_addr=fetch_pc, then fetch_pc += PC_STEP (mod 2^DATA_W, wraps silently), inflight=1.
- Response: the cycle after an issue, if not killed, push {imem_rdata, issued pc} into the FIFO. Credit check guarantees no overflow.
- Handshake:
  - Pop on out_valid & out_ready.
  - out_valid = FIFO non-empty.
  - out_instr/out_pc are held stable while out_valid=1 and out_ready=0.
- Simultaneous push and pop: allowed at any occupancy including full (credit-limited) and empty (pushed entry becomes visible next cycle).
- Redirect (highest priority):
  - Same edge: FIFO cleared, fetch_pc = {redirect_pc[DATA_W-1:2],2'b00}.
  - Any inflight response is killed and not written.
  - A simultaneous pop is discarded.
  - No issue in the redirect cycle; first fetch at the new PC the next cycle, if in RUN.
  - Redirect while IDLE or DRAIN updates fetch_pc only.
- Latency: redirect/enable to first out_valid = 2 cycles (issue, write, visible). Sustained throughput is 1 instruction/cycle while out_ready=1.
- Pointers: log2(FIFO_DEPTH) bits, wrap naturally. Count is tracked separately to distinguish full from empty.

Optional Feature:
FETCH_BYPASS_EN
- Defined:
  - When the FIFO is empty and a non-killed response arrives, present it combinationally: out_valid=1, out_instr=imem_rdata, out_pc=issued pc.
  - If out_ready=1 it is consumed without a push. Otherwise it is pushed normally.
  - Fetch-to-out_valid latency becomes 1 cycle.
  - Redirect still kills the response.
- Undefined: latency 2 cycles as above; no combinational path from imem_rdata to outputs.

Decomposition:
- Package cpu_pkg:
  - INSTR_W and PC_STEP defaults.
  - NOP encoding 32'h00000013.
  - FSM state enum {IDLE, RUN, DRAIN}.
  - Pointer/count width function.
- Sub-module sync_fifo:
  - Parameters: width = INSTR_W+DATA_W, depth = FIFO_DEPTH.
  - Ports: push, pop, flush, full, empty, count.
  - Synchronous active-high reset.

Test Plan:
- Reset then enable=1, out_ready=1, imem returns addr>>2 -> imem_addr 0,4,8,...; out_pc 0,4,8 one per cycle from cycle 2; out_instr 0,1,2.
- out_ready=0 with FIFO_DEPTH=4 -> exactly 4 issues (PC 0..12); imem_ren stays 0; fifo_count=4; outputs stable. Release ready -> 0,4,8,12,16 in order, no gaps after the first.
- redirect=1, redirect_pc=0x103 while FIFO holds 3 entries and a read is inflight -> next cycle fifo_count=0, out_valid=0. Next issue addr 0x100; out_pc 0x100 after 2 cycles; killed data never appears.
- enable dropped with 2 entries buffered -> DRAIN, no further imem_ren, both entries delivered, then IDLE.
- fetch_pc=2^64-4 -> issues 0xFFFF_FFFF_FFFF_FFFC then 0.
- With FETCH_BYPASS_EN, empty FIFO and out_ready=1 -> out_valid in the same cycle as imem_rdata, fifo_count stays 0.
